// File: rtl/ikaopm_dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ikaopm_dac_pkg
//  Brief    : Shared slot constants, word field layout and framing state
//             type for the OPM serial DAC receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package ikaopm_dac_pkg;

    // Slot positions within one 16-slot half (R or L word)
    localparam int SLOT_S    = 9;    // sign bit (1 = positive)
    localparam int SLOT_E0   = 10;   // exponent bit 0
    localparam int SLOT_LAST = 12;   // last meaningful bit (e[2])
    localparam int SLOT_STRB = 13;   // slot on which the decoded word is presented
    localparam int HALF      = 16;   // slots per channel word
    localparam int FRAME     = 32;   // slots per stereo frame

    localparam int SLOT_W    = 5;    // slot counter width
    localparam logic [SLOT_W-1:0] SLOT_WRAP = 5'(FRAME - 1);

    // 13-bit captured word layout
    localparam int WORD_W = 13;
    localparam int M_LSB  = 0;
    localparam int M_W    = 9;
    localparam int S_POS  = SLOT_S;
    localparam int E_LSB  = SLOT_E0;
    localparam int E_W    = 3;

    // Framing state
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } dac_state_t;

    // Two's complement mantissa: the transmitted sign bit is inverted
    function automatic logic [9:0] word_v10(input logic [WORD_W-1:0] w);
        return {~w[S_POS], w[M_LSB +: M_W]};
    endfunction

    function automatic logic [E_W-1:0] word_exp(input logic [WORD_W-1:0] w);
        return w[E_LSB +: E_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ikaopm_dac_chdec.sv
`default_nettype none
// ============================================================================
//  Module   : ikaopm_dac_chdec
//  Brief    : Combinational OPM float to signed 16-bit PCM decode for one
//             channel. PCM = sext(v10) << (e-1); e=0 either behaves as e=1
//             or forces silence, chosen by E0_AS_E1.
//  Revision : 1.0 - initial release
// ============================================================================
module ikaopm_dac_chdec
    import ikaopm_dac_pkg::*;
#(
    parameter bit E0_AS_E1 = 1'b1
) (
    input  logic signed [9:0]     i_v10,
    input  logic        [E_W-1:0] i_exp,
    output logic signed [15:0]    o_pcm
);

    logic signed [15:0] w_ext;
    logic        [2:0]  w_shamt;

    // Sign-extend the mantissa and shift by (e-1); the largest magnitude,
    // -512 << 6, is exactly -32768, so no saturation is ever required.
    always_comb begin
        w_ext   = {{6{i_v10[9]}}, i_v10};
        w_shamt = (i_exp == 3'd0) ? 3'd0 : (i_exp - 3'd1);
        o_pcm   = w_ext <<< w_shamt;
        if ((i_exp == 3'd0) && !E0_AS_E1) begin
            o_pcm = 16'sd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ikaopm_dac_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ikaopm_dac_rx
//  Brief    : Receiver for the OPM serial sound stream (SO pin). Locks to the
//             frame sync, deserialises the 32-slot R/L frame, decodes each
//             13-bit float word to signed PCM and strobes the outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module ikaopm_dac_rx
    import ikaopm_dac_pkg::*;
#(
    parameter int SYNC_LOSS_LIMIT = 4,     // 1..15 missed syncs before unlock
    parameter bit E0_AS_E1        = 1'b1
) (
    input  logic               i_EMUCLK,
    input  logic               i_MRST,
    input  logic               i_phi1_NCEN_n,
    input  logic               i_SO,
    input  logic               i_FRAME_SYNC,
    output logic               o_LOCK,
    output logic               o_SYNC_ERR,
    output logic signed [15:0] o_EMU_R,
    output logic signed [15:0] o_EMU_L,
    output logic               o_EMU_R_SAMPLE,
    output logic               o_EMU_L_SAMPLE
);

    localparam logic [3:0] MISS_LIMIT = 4'(SYNC_LOSS_LIMIT);
    localparam logic [3:0] POS_LAST   = 4'(SLOT_LAST);
    localparam logic [3:0] POS_STRB   = 4'(SLOT_STRB);

    // Framing
    dac_state_t        r_state;
    dac_state_t        w_state_nxt;
    logic [SLOT_W-1:0] r_slot;        // slot of the most recently accepted bit
    logic [SLOT_W-1:0] w_slot_nxt;    // slot of the bit arriving this cycle
    logic [3:0]        r_miss;
    logic [3:0]        w_miss_nxt;
    logic              w_en;
    logic              w_capture;     // this cycle's bit belongs to a locked frame
    logic              w_sync_err;
    logic              w_drop;        // lock is being lost this cycle

    // Slot decomposition of the incoming bit
    logic              w_half;        // 0 = R word, 1 = L word
    logic [3:0]        w_pos;         // position inside the word

    // Capture registers and word validity
    logic [WORD_W-1:0] r_word_r;
    logic [WORD_W-1:0] r_word_l;
    logic              r_vld_r;       // R word capture started at slot 0 while locked
    logic              r_vld_l;

    // Output registers
    logic               r_lock;
    logic               r_sync_err;
    logic               r_strb_r;
    logic               r_strb_l;
    logic signed [15:0] r_emu_r;
    logic signed [15:0] r_emu_l;

    // Decoder interface
    logic signed [9:0]     w_v10_r;
    logic signed [9:0]     w_v10_l;
    logic        [E_W-1:0] w_exp_r;
    logic        [E_W-1:0] w_exp_l;
    logic signed [15:0]    w_pcm_r;
    logic signed [15:0]    w_pcm_l;

    assign w_en   = ~i_phi1_NCEN_n;
    assign w_half = w_slot_nxt[SLOT_W-1];
    assign w_pos  = w_slot_nxt[SLOT_W-2:0];

    // Framing state, slot counter and miss counter registers
    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            r_state <= IDLE;
            r_slot  <= '0;
            r_miss  <= '0;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_miss  <= w_miss_nxt;
            r_lock  <= (w_state_nxt == LOCKED);
        end
    end

    // Next framing state: acquire on sync, realign on early sync, count
    // frame boundaries that pass without a sync and give up at the limit.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_miss_nxt  = r_miss;
        w_capture   = 1'b0;
        w_sync_err  = 1'b0;
        w_drop      = 1'b0;

        if (w_en) begin
            case (r_state)
                IDLE: begin
                    if (i_FRAME_SYNC) begin
                        w_state_nxt = LOCKED;
                        w_slot_nxt  = '0;
                        w_miss_nxt  = '0;
                        w_capture   = 1'b1;
                    end
                end

                LOCKED: begin
                    if (i_FRAME_SYNC) begin
                        w_slot_nxt = '0;
                        w_capture  = 1'b1;
                        if (r_slot == SLOT_WRAP) begin
                            w_miss_nxt = '0;
                        end else begin
                            w_sync_err = 1'b1;
                        end
                    end else begin
                        w_slot_nxt = r_slot + 5'd1;
                        w_capture  = 1'b1;
                        if (r_slot == SLOT_WRAP) begin
                            if ((r_miss + 4'd1) >= MISS_LIMIT) begin
                                w_state_nxt = IDLE;
                                w_slot_nxt  = '0;
                                w_miss_nxt  = '0;
                                w_capture   = 1'b0;
                                w_drop      = 1'b1;
                            end else begin
                                w_miss_nxt = r_miss + 4'd1;
                            end
                        end
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                    w_slot_nxt  = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

    // Bit capture into the word of the current half, word validity tracking,
    // and the output update + one-cycle strobe on the slot after e[2].
    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            r_word_r   <= '0;
            r_word_l   <= '0;
            r_vld_r    <= 1'b0;
            r_vld_l    <= 1'b0;
            r_sync_err <= 1'b0;
            r_strb_r   <= 1'b0;
            r_strb_l   <= 1'b0;
            r_emu_r    <= '0;
            r_emu_l    <= '0;
        end else begin
            r_sync_err <= w_sync_err;
            r_strb_r   <= 1'b0;
            r_strb_l   <= 1'b0;

            if (w_drop) begin
                r_vld_r <= 1'b0;
                r_vld_l <= 1'b0;
            end

            // An early sync abandons the half in progress; the R half restarts
            // below with the realigned slot 0, the L half must wait for slot 16.
            if (w_sync_err) begin
                r_vld_l <= 1'b0;
            end

            if (w_capture) begin
                if (w_pos <= POS_LAST) begin
                    if (w_half) begin
                        r_word_l[w_pos] <= i_SO;
                    end else begin
                        r_word_r[w_pos] <= i_SO;
                    end
                end

                if (w_pos == 4'd0) begin
                    if (w_half) begin
                        r_vld_l <= 1'b1;
                    end else begin
                        r_vld_r <= 1'b1;
                    end
                end

                // The word registers already hold bits 0..12 at this point
                if (w_pos == POS_STRB) begin
                    if (!w_half && r_vld_r) begin
                        r_emu_r  <= w_pcm_r;
                        r_strb_r <= 1'b1;
                    end
                    if (w_half && r_vld_l) begin
                        r_emu_l  <= w_pcm_l;
                        r_strb_l <= 1'b1;
                    end
                end
            end
        end
    end

    assign w_v10_r = word_v10(r_word_r);
    assign w_v10_l = word_v10(r_word_l);
    assign w_exp_r = word_exp(r_word_r);
    assign w_exp_l = word_exp(r_word_l);

    ikaopm_dac_chdec #(
        .E0_AS_E1 (E0_AS_E1)
    ) u_chdec_r (
        .i_v10 (w_v10_r),
        .i_exp (w_exp_r),
        .o_pcm (w_pcm_r)
    );

    ikaopm_dac_chdec #(
        .E0_AS_E1 (E0_AS_E1)
    ) u_chdec_l (
        .i_v10 (w_v10_l),
        .i_exp (w_exp_l),
        .o_pcm (w_pcm_l)
    );

    assign o_LOCK         = r_lock;
    assign o_SYNC_ERR     = r_sync_err;
    assign o_EMU_R        = r_emu_r;
    assign o_EMU_L        = r_emu_l;
    assign o_EMU_R_SAMPLE = r_strb_r;
    assign o_EMU_L_SAMPLE = r_strb_l;

endmodule
`default_nettype wire

// File: tb/tb_ikaopm_dac_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ikaopm_dac_rx
//  Brief    : Self-checking bench for ikaopm_dac_rx. Serial frames are built
//             from random float fields; expected PCM is computed arithmetically
//             from the float definition and compared with strobed outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ikaopm_dac_rx;

    localparam int LIMIT = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic ncen   = 1'b1;
    logic so_i   = 1'b0;
    logic sync_i = 1'b0;

    logic        lock, serr, sr, sl;
    logic [15:0] emu_r, emu_l;
    logic        lock2, serr2, sr2, sl2;
    logic [15:0] emu_r2, emu_l2;

    int n_cmp     = 0;
    int n_fail    = 0;
    int gap_max   = 0;
    int n_serr    = 0;
    int width_err = 0;
    logic prev_sr = 1'b0;
    logic prev_sl = 1'b0;

    // {slot label, pcm} of observed and expected strobes
    logic [31:0] obs_r[$];
    logic [31:0] obs_l[$];
    logic [31:0] exp_r[$];
    logic [31:0] exp_l[$];
    logic [15:0] last_r = '0;
    logic [15:0] last_l = '0;

    always #5 clk = ~clk;

    ikaopm_dac_rx #(.SYNC_LOSS_LIMIT(LIMIT), .E0_AS_E1(1'b1)) dut (
        .i_EMUCLK       (clk),
        .i_MRST         (rst),
        .i_phi1_NCEN_n  (ncen),
        .i_SO           (so_i),
        .i_FRAME_SYNC   (sync_i),
        .o_LOCK         (lock),
        .o_SYNC_ERR     (serr),
        .o_EMU_R        (emu_r),
        .o_EMU_L        (emu_l),
        .o_EMU_R_SAMPLE (sr),
        .o_EMU_L_SAMPLE (sl)
    );

    ikaopm_dac_rx #(.SYNC_LOSS_LIMIT(LIMIT), .E0_AS_E1(1'b0)) dut_e0 (
        .i_EMUCLK       (clk),
        .i_MRST         (rst),
        .i_phi1_NCEN_n  (ncen),
        .i_SO           (so_i),
        .i_FRAME_SYNC   (sync_i),
        .o_LOCK         (lock2),
        .o_SYNC_ERR     (serr2),
        .o_EMU_R        (emu_r2),
        .o_EMU_L        (emu_l2),
        .o_EMU_R_SAMPLE (sr2),
        .o_EMU_L_SAMPLE (sl2)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Float definition: value = (s ? m : m-512) * 2^(e-1)
    function automatic logic [15:0] ref_pcm(input int s, input int m, input int e, input bit e0_as_e1);
        int v;
        int ee;
        v  = (s != 0) ? m : (m - 512);
        ee = e;
        if (e == 0) begin
            if (!e0_as_e1) return 16'h0000;
            ee = 1;
        end
        return 16'(v * (1 << (ee - 1)));
    endfunction

    // Word with random junk in the ignored slots 13-15
    function automatic logic [15:0] mkw(input int s, input int m, input int e);
        logic [15:0] w;
        w        = 16'($urandom);
        w[8:0]   = 9'(m);
        w[9]     = (s != 0);
        w[12:10] = 3'(e);
        return w;
    endfunction

    task automatic observe(input int label);
        if (sr) obs_r.push_back({16'(label), emu_r});
        if (sl) obs_l.push_back({16'(label), emu_l});
        if (sr && prev_sr) width_err++;
        if (sl && prev_sl) width_err++;
        prev_sr = sr;
        prev_sl = sl;
        if (serr) n_serr++;
    endtask

    // One enabled bit, optionally preceded by 1..gap_max disabled cycles of noise
    task automatic step(input logic so, input logic sync, input int label);
        int gap;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            ncen = 1'b1; so_i = 1'($urandom); sync_i = 1'($urandom);
            @(posedge clk); #1;
            observe(-1);
        end
        @(negedge clk);
        ncen = 1'b0; so_i = so; sync_i = sync;
        @(posedge clk); #1;
        observe(label);
    endtask

    task automatic send_range(input logic [31:0] fr, input bit sync0, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(fr[i], sync0 && (i == lo), i);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; ncen = 1'($urandom); so_i = 1'($urandom); sync_i = 1'($urandom);
            @(posedge clk); #1;
            observe(-1);
        end
        @(negedge clk);
        rst = 1'b0; ncen = 1'b1; sync_i = 1'b0;
    endtask

    task automatic run_frame(input int rs, input int rm, input int re,
                             input int ls, input int lm, input int le,
                             input bit sy, input bit ex);
        logic [31:0] fr;
        fr = {mkw(ls, lm, le), mkw(rs, rm, re)};
        send_range(fr, sy, 0, 31);
        if (ex) begin
            last_r = ref_pcm(rs, rm, re, 1'b1);
            last_l = ref_pcm(ls, lm, le, 1'b1);
            exp_r.push_back({16'd13, last_r});
            exp_l.push_back({16'd29, last_l});
        end
    endtask

    task automatic run_random(input bit sy, input bit ex);
        run_frame($urandom_range(1, 0), $urandom_range(511, 0), $urandom_range(7, 0),
                  $urandom_range(1, 0), $urandom_range(511, 0), $urandom_range(7, 0), sy, ex);
    endtask

    task automatic check_queues(input string tag);
        int n;
        chk({tag, "_r_count"}, obs_r.size(), exp_r.size());
        chk({tag, "_l_count"}, obs_l.size(), exp_l.size());
        n = (obs_r.size() < exp_r.size()) ? obs_r.size() : exp_r.size();
        for (int i = 0; i < n; i++) chk({tag, "_r_sample"}, obs_r[i], exp_r[i]);
        n = (obs_l.size() < exp_l.size()) ? obs_l.size() : exp_l.size();
        for (int i = 0; i < n; i++) chk({tag, "_l_sample"}, obs_l[i], exp_l[i]);
        obs_r.delete(); obs_l.delete(); exp_r.delete(); exp_l.delete();
    endtask

    initial begin
        logic [31:0] fr;

        // Reset state
        do_reset(3);
        chk("rst_lock", lock, 0);
        chk("rst_serr", serr, 0);
        chk("rst_r", emu_r, 0);
        chk("rst_l", emu_l, 0);
        chk("rst_strobes", {sr, sl}, 0);

        // Idle stream without sync
        for (int i = 0; i < 40; i++) step(1'($urandom), 1'b0, -1);
        chk("idle_lock", lock, 0);
        chk("idle_r", emu_r, 0);
        chk("idle_l", emu_l, 0);
        check_queues("idle");

        // First lock and directed words
        run_frame(1, 'h100, 3, 0, 0, 7, 1'b1, 1'b1);
        chk("lock_acq", lock, 1);
        chk("first_r", emu_r, 16'h0400);
        chk("first_l", emu_l, 16'h8000);
        check_queues("first");

        run_frame(1, 'h1FF, 7, 1, 0, 1, 1'b1, 1'b1);
        chk("max_pos_r", emu_r, 16'h7FC0);
        run_frame(0, 'h1FF, 1, 0, 'h1FF, 1, 1'b1, 1'b1);
        chk("minus1_r", emu_r, 16'hFFFF);
        chk("e0dut_minus1_r", emu_r2, 16'hFFFF);
        run_frame(1, 'h0AB, 0, 0, 'h055, 0, 1'b1, 1'b1);
        chk("e0_as_e1_r", emu_r, ref_pcm(1, 'h0AB, 1, 1'b1));
        chk("e0_zero_r", emu_r2, 16'h0000);
        chk("e0_zero_l", emu_l2, 16'h0000);
        chk("e0dut_lock", lock2, 1);
        chk("e0dut_quiet", {serr2, sr2, sl2}, 0);

        // Randomised words with regular syncs
        for (int k = 0; k < 16; k++) run_random(1'b1, 1'b1);
        check_queues("random");
        chk("no_sync_err", n_serr, 0);

        // Early sync at slot 7 interrupts an R word
        fr = {mkw(1, 'h123, 4), mkw(0, 'h0F0, 5)};
        send_range(fr, 1'b1, 0, 6);
        run_random(1'b1, 1'b1);
        chk("sync_err_pulse", n_serr, 1);
        run_random(1'b1, 1'b1);
        chk("sync_err_once", n_serr, 1);
        check_queues("realign");

        // Sync loss: frames keep decoding until the LIMIT-th missed boundary
        for (int k = 1; k <= LIMIT; k++) begin
            if (k < LIMIT) begin
                run_random(1'b0, 1'b1);
            end else begin
                chk("lock_before_loss", lock, 1);
                fr = {mkw(1, 'h1AA, 6), mkw(1, 'h155, 6)};
                send_range(fr, 1'b0, 0, 0);
                chk("lock_lost", lock, 0);
                send_range(fr, 1'b0, 1, 31);
            end
        end
        check_queues("flywheel");
        chk("hold_r", emu_r, last_r);
        chk("hold_l", emu_l, last_l);
        chk("still_unlocked", lock, 0);
        run_random(1'b1, 1'b1);
        chk("relock", lock, 1);
        check_queues("relock");

        // Irregular enable with noise on disabled cycles
        gap_max = 3;
        run_frame(1, 'h100, 3, 0, 0, 7, 1'b1, 1'b1);
        run_frame(1, 'h1FF, 7, 0, 'h1FF, 1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) run_random(1'b1, 1'b1);
        gap_max = 0;
        check_queues("gapped");
        chk("strobe_width", width_err, 0);
        chk("gapped_sync_err", n_serr, 1);

        // Reset asserted at slot 11 discards the word
        fr = {mkw(1, 'h0FF, 7), mkw(1, 'h0FF, 7)};
        send_range(fr, 1'b1, 0, 11);
        do_reset(1);
        chk("mid_rst_lock", lock, 0);
        chk("mid_rst_r", emu_r, 0);
        send_range(fr, 1'b0, 12, 31);
        check_queues("reset_mid");
        chk("after_rst_r", emu_r, 0);
        chk("after_rst_l", emu_l, 0);
        chk("after_rst_lock", lock, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ikaopm_dac_rx.md
Name: ikaopm_dac_rx

Overview:
Receiver for the OPM serial floating-point sound stream, i.e. the DAC end of the SO pin. It deserializes the 32-slot stereo frame (R word then L word, 16 slots each), decodes each 13-bit float (9-bit mantissa, flipped-sign bit, 3-bit exponent) to signed 16-bit PCM, and presents parallel samples with strobes. Used on the emulator side to loop back or monitor the core's serial output and to drive a PCM sink.

Parameters:
SYNC_LOSS_LIMIT, 4, consecutive missing frame syncs tolerated before lock is dropped (1..15).
E0_AS_E1, 1, 1: exponent 0 decodes as exponent 1; 0: exponent 0 decodes to 16'sd0.

Ports:
i_EMUCLK  in  1  emulator master clock; all state on posedge.
i_MRST  in  1  reset; synchronous, active-high.
i_phi1_NCEN_n  in  1  clock enable, active-low; slot logic advances only when low.
i_SO  in  1  serial sound data; one bit per enabled cycle.
i_FRAME_SYNC  in  1  high in the enabled cycle carrying bit 0 of the R word.
o_LOCK  out  1  frame alignment valid.
o_SYNC_ERR  out  1  one-EMUCLK pulse on a sync at an unexpected slot.
o_EMU_R, o_EMU_L  out  16 signed  decoded PCM.
o_EMU_R_SAMPLE, o_EMU_L_SAMPLE  out  1  one-EMUCLK pulse when the matching output updates.

Behaviour:
- Reset (i_MRST high at posedge, overrides enable): state IDLE, slot counter 0, miss counter 0, shift registers 0; o_LOCK=0, o_SYNC_ERR=0, o_EMU_R=o_EMU_L=0, both SAMPLE strobes 0. Reset asserted mid-word discards the word with no output update.
- Word format, LSB first, slots 0..15 of each half: 0-8 m[0..8], 9 s (1 = positive), 10-12 e[0..2], 13-15 ignored.
- Decode: v10 = {~s, m} as two's complement (range -512..511). PCM = sign-extended v10 << (e-1) for e=1..7. For e=0, follow E0_AS_E1. No saturation is needed: the result always fits in 16 bits.
- Slot counter is 5 bits. Slots 0-15 carry R and slots 16-31 carry L. The counter advances only on enabled cycles and wraps 31→0.
- States:
  - IDLE: nothing is captured. A sync → LOCKED with slot=0, bit 0 captured in the same cycle, miss counter cleared.
  - LOCKED: next slot = sync ? 0 : slot+1.
    - Sync when the current slot is 31: expected; clear the miss counter.
    - Sync when the current slot is not 31: o_SYNC_ERR pulse, realign to 0, and discard the partially captured word of the interrupted half (no strobe for it).
    - Slot 31→0 with no sync: miss counter +1. When it reaches SYNC_LOSS_LIMIT → IDLE, o_LOCK=0. Outputs keep their last values.
- o_LOCK = (state == LOCKED), registered.
- Latency:
  - Bit 12 (e[2]) of a half is captured on enabled slot 12 or 28.
  - On the next enabled cycle (slot 13 or 29), the decoded value is registered into o_EMU_R or o_EMU_L, and the matching SAMPLE strobe goes high for exactly that one EMUCLK cycle.
  - Slots 13-15 never alter the captured word.
- Bits arriving on cycles with i_phi1_NCEN_n high are ignored. i_FRAME_SYNC is sampled only on enabled cycles.
- A word whose capture began before lock was acquired is never output.

Decomposition:
- Shared package ikaopm_dac_pkg holds:
  - slot constants: SLOT_S=9, SLOT_E0=10, SLOT_LAST=12, SLOT_STRB=13, HALF=16, FRAME=32;
  - the 2-state enum (IDLE, LOCKED);
  - the 13-bit word field offsets.
- Sub-module ikaopm_dac_chdec: combinational float→PCM16 decode (v10, e, E0_AS_E1 → signed 16-bit). It is instantiated twice, once for R and once for L.
- Framing, shift registers, and strobes stay in the top module.

Test Plan:
- Reset then idle stream: o_EMU_R=o_EMU_L=0 and o_LOCK=0 throughout; no strobes until the first sync.
- Sync + R word s=1, m=9'h100, e=3, then L word s=0, m=0, e=7 → o_EMU_R=16'h0400 at R slot 13 with one R strobe; o_EMU_L=16'h8000 at L slot 29 (slot 13 of the L half) with one L strobe.
- R word s=1, m=9'h1FF, e=7 → 16'h7FC0. R word s=0, m=9'h1FF, e=1 → 16'hFFFF. With E0_AS_E1=0, e=0 → 16'h0000.
- Sync injected at slot 7 of the R word → o_SYNC_ERR pulse, no R strobe for the interrupted word, and the next full R word decodes correctly from the new alignment.
- Syncs stop after lock (SYNC_LOSS_LIMIT=4) → o_LOCK drops after the 4th missed boundary; outputs hold their values; the next sync relocks.
- Enable toggled irregularly (high 1-3 EMUCLKs between enables) with the same words → identical decoded values. Each strobe is exactly one EMUCLK wide. Reset asserted at slot 11 → no output update for that word.
